hazard_scoreboard: RTL and testbench

- Sequential hazard unit for the 5-stage MIPS pipeline, the parametrised successor to the combinational Tuse/Tnew decoder.
- Takes per-instruction Tuse/Tnew values from D-stage decode and tracks destination register and remaining Tnew for the E, M and W stages in a register scoreboard.
- Drives stall and D-stage forwarding selects.
- Adds a multi-cycle HI/LO busy counter for mult/div.

---
 rtl/hazard_scoreboard_pkg.sv | 28 ++
 rtl/hazard_scoreboard_operand_check.sv | 45 ++++
 rtl/hazard_scoreboard.sv | 90 +++++++++
 tb/tb_hazard_scoreboard.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the Tuse/Tnew hazard scoreboard:
// forwarding select codes, scoreboard entry layout and Tnew ageing.
package hazard_scoreboard_pkg;

   localparam int RAW_W = 5;
   localparam int TW_W  = 2;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_E  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;
   localparam logic [1:0] FWD_W  = 2'b11;

   localparam logic [TW_W-1:0] TUSE_NONE = '1;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   typedef struct packed {
      logic [RAW_W-1:0] dst;
      logic [TW_W-1:0]  tnew;
   } entry_t;

   // Tnew counts down one per stage and stops at zero (result is ready).
   function automatic logic [TW_W-1:0] sat_dec(input logic [TW_W-1:0] v);
      return (v == '0) ? '0 : v - TW_W'(1);
   endfunction

endpackage

// File: rtl/hazard_scoreboard_operand_check.sv
// Per-operand hazard check: finds the youngest in-flight writer of the
// operand and derives its stall term and D-stage forwarding select.
module hazard_operand_check
   import hazard_scoreboard_pkg::*;
(
   input  logic             i_valid,
   input  logic [RAW_W-1:0] i_addr,
   input  logic [TW_W-1:0]  i_tuse,
   input  entry_t           i_e,
   input  entry_t           i_m,
   input  entry_t           i_w,
   output logic             o_stall,
   output logic [1:0]       o_fwd_sel
);

   logic            w_hit;
   logic [TW_W-1:0] w_tnew;
   logic [1:0]      w_code;

   // Only the youngest matching stage matters; older copies are stale.
   always_comb begin
      w_hit  = 1'b0;
      w_tnew = '0;
      w_code = FWD_RF;
      if (i_addr != '0) begin
         if (i_e.dst == i_addr) begin
            w_hit  = 1'b1;
            w_tnew = i_e.tnew;
            w_code = FWD_E;
         end else if (i_m.dst == i_addr) begin
            w_hit  = 1'b1;
            w_tnew = i_m.tnew;
            w_code = FWD_M;
         end else if (i_w.dst == i_addr) begin
            w_hit  = 1'b1;
            w_tnew = i_w.tnew;
            w_code = FWD_W;
         end
      end
   end

   assign o_stall   = i_valid && (i_tuse != TUSE_NONE) && w_hit && (w_tnew > i_tuse);
   assign o_fwd_sel = (w_hit && (w_tnew == '0)) ? w_code : FWD_RF;

endmodule

// File: rtl/hazard_scoreboard.sv
// Sequential hazard unit for the 5-stage MIPS pipeline: E/M/W scoreboard of
// (dst, tnew), D-stage stall/forward decisions and a HI/LO busy counter.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int RAW         = RAW_W,
   parameter int TW          = TW_W,
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int CW          = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           d_valid,
   input  logic [RAW-1:0] d_rs,
   input  logic [RAW-1:0] d_rt,
   input  logic [TW-1:0]  d_tuse_rs,
   input  logic [TW-1:0]  d_tuse_rt,
   input  logic [RAW-1:0] d_dst,
   input  logic [TW-1:0]  d_tnew,
   input  logic           d_md_start,
   input  logic           d_md_div,
   input  logic           d_hilo_use,
   output logic           stall,
   output logic [1:0]     fwd_rs_sel,
   output logic [1:0]     fwd_rt_sel,
   output logic           md_busy
);

   entry_t          r_e;
   entry_t          r_m;
   entry_t          r_w;
   logic [CW-1:0]   r_md_cnt;

   logic            w_rs_stall;
   logic            w_rt_stall;
   logic            w_md_stall;
   logic            w_accept;

   hazard_operand_check u_rs_check (
      .i_valid   (d_valid),
      .i_addr    (d_rs),
      .i_tuse    (d_tuse_rs),
      .i_e       (r_e),
      .i_m       (r_m),
      .i_w       (r_w),
      .o_stall   (w_rs_stall),
      .o_fwd_sel (fwd_rs_sel)
   );

   hazard_operand_check u_rt_check (
      .i_valid   (d_valid),
      .i_addr    (d_rt),
      .i_tuse    (d_tuse_rt),
      .i_e       (r_e),
      .i_m       (r_m),
      .i_w       (r_w),
      .o_stall   (w_rt_stall),
      .o_fwd_sel (fwd_rt_sel)
   );

   assign md_busy    = (r_md_cnt != '0);
   assign w_md_stall = d_valid && d_hilo_use && md_busy;
   assign stall      = w_rs_stall || w_rt_stall || w_md_stall;
   assign w_accept   = d_valid && !stall;

   // Pipeline advances every cycle; a stalled or empty D slot becomes a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_e      <= '0;
         r_m      <= '0;
         r_w      <= '0;
         r_md_cnt <= '0;
      end else begin
         r_w <= '{dst: r_m.dst, tnew: sat_dec(r_m.tnew)};
         r_m <= '{dst: r_e.dst, tnew: sat_dec(r_e.tnew)};
         if (w_accept) begin
            r_e <= '{dst: d_dst, tnew: sat_dec(d_tnew)};
         end else begin
            r_e <= '0;
         end
         if (w_accept && d_md_start) begin
            r_md_cnt <= d_md_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
         end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed pipeline scenarios with
// literal expectations, then randomized traffic against an age-based model.
module tb_hazard_scoreboard;

   logic       clk;
   logic       rst_n;
   logic       d_valid;
   logic [4:0] d_rs;
   logic [4:0] d_rt;
   logic [1:0] d_tuse_rs;
   logic [1:0] d_tuse_rt;
   logic [4:0] d_dst;
   logic [1:0] d_tnew;
   logic       d_md_start;
   logic       d_md_div;
   logic       d_hilo_use;
   logic       stall;
   logic [1:0] fwd_rs_sel;
   logic [1:0] fwd_rt_sel;
   logic       md_busy;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 0;

   hazard_scoreboard dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .d_valid    (d_valid),
      .d_rs       (d_rs),
      .d_rt       (d_rt),
      .d_tuse_rs  (d_tuse_rs),
      .d_tuse_rt  (d_tuse_rt),
      .d_dst      (d_dst),
      .d_tnew     (d_tnew),
      .d_md_start (d_md_start),
      .d_md_div   (d_md_div),
      .d_hilo_use (d_hilo_use),
      .stall      (stall),
      .fwd_rs_sel (fwd_rs_sel),
      .fwd_rt_sel (fwd_rt_sel),
      .md_busy    (md_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: history of issued instructions (raw D-stage Tnew), newest last.
   // An instruction that has been in flight for a stages has tnew = d_tnew-(a+1).
   typedef struct {
      int dst;
      int tn;
   } ent_t;

   ent_t q[$];
   int   edges = 0;
   int   md_n  = 0;
   int   md_at = 0;

   function automatic void model_reset();
      q.delete();
      for (int i = 0; i < 3; i++) q.push_back('{dst: 0, tn: 0});
      md_n = 0;
      md_at = 0;
   endfunction

   function automatic int stage_tnew(input int age);
      int t;
      t = q[2-age].tn - (age + 1);
      return (t < 0) ? 0 : t;
   endfunction

   function automatic int md_rem();
      int r;
      r = md_n - (edges - md_at);
      return (r < 0) ? 0 : r;
   endfunction

   function automatic int op_stall(input int addr, input int tuse);
      if (addr == 0) return 0;
      for (int a = 0; a < 3; a++) begin
         if (q[2-a].dst == addr)
            return (d_valid && tuse != 3 && stage_tnew(a) > tuse) ? 1 : 0;
      end
      return 0;
   endfunction

   function automatic int op_sel(input int addr);
      if (addr == 0) return 0;
      for (int a = 0; a < 3; a++) begin
         if (q[2-a].dst == addr)
            return (stage_tnew(a) == 0) ? a + 1 : 0;
      end
      return 0;
   endfunction

   function automatic int exp_stall();
      int s;
      s = op_stall(int'(d_rs), int'(d_tuse_rs)) | op_stall(int'(d_rt), int'(d_tuse_rt));
      if (d_valid && d_hilo_use && md_rem() > 0) s = 1;
      return s;
   endfunction

   always @(posedge clk) begin
      if (rst_n) begin
         int s;
         s = exp_stall();
         edges++;
         if (d_valid && s == 0) q.push_back('{dst: int'(d_dst), tn: int'(d_tnew)});
         else                   q.push_back('{dst: 0, tn: 0});
         void'(q.pop_front());
         if (d_valid && s == 0 && d_md_start) begin
            md_n  = d_md_div ? 10 : 5;
            md_at = edges;
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model_stall",   int'(stall),      exp_stall());
         chk("model_fwd_rs",  int'(fwd_rs_sel), op_sel(int'(d_rs)));
         chk("model_fwd_rt",  int'(fwd_rt_sel), op_sel(int'(d_rt)));
         chk("model_md_busy", int'(md_busy),    (md_rem() > 0) ? 1 : 0);
      end
   end

   task automatic drv(input bit v, input int rs, input int rt, input int trs, input int trt,
                      input int dst, input int tn, input bit mds, input bit mdd, input bit hl);
      d_valid    = v;
      d_rs       = 5'(rs);
      d_rt       = 5'(rt);
      d_tuse_rs  = 2'(trs);
      d_tuse_rt  = 2'(trt);
      d_dst      = 5'(dst);
      d_tnew     = 2'(tn);
      d_md_start = mds;
      d_md_div   = mdd;
      d_hilo_use = hl;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      drv(0, 0, 0, 3, 3, 0, 0, 0, 0, 0);
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      cmp_en = 1;

      @(negedge clk);
      $display("txn reset_release");
      chk("rst_stall", int'(stall), 0);
      chk("rst_fwd_rs", int'(fwd_rs_sel), 0);
      chk("rst_md_busy", int'(md_busy), 0);

      // Asynchronous reset while r5 (E tnew=1) is in flight.
      next_cycle(); drv(1, 0, 0, 3, 3, 5, 2, 0, 0, 0);
      next_cycle(); drv(1, 5, 5, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      $display("txn read_r5_before_reset");
      chk("pre_rst_stall", int'(stall), 1);
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      $display("txn async_reset");
      chk("async_rst_stall", int'(stall), 0);
      chk("async_rst_fwd_rs", int'(fwd_rs_sel), 0);
      chk("async_rst_md_busy", int'(md_busy), 0);
      next_cycle(); rst_n = 1'b1;

      // lw r8 ; addu r9,r8,r8
      drv(1, 0, 0, 3, 3, 8, 3, 0, 0, 0);
      next_cycle(); drv(1, 8, 8, 1, 1, 9, 1, 0, 0, 0);
      @(negedge clk);
      $display("txn addu_after_lw");
      chk("lw_use_stall", int'(stall), 1);
      next_cycle();
      @(negedge clk);
      chk("lw_use_release", int'(stall), 0);
      chk("lw_use_fwd_m_notready", int'(fwd_rs_sel), 0);
      next_cycle(); drv(1, 8, 0, 1, 1, 10, 1, 0, 0, 0);
      @(negedge clk);
      $display("txn subu_reads_r8_from_w");
      chk("lw_fwd_w", int'(fwd_rs_sel), 3);
      chk("lw_fwd_w_stall", int'(stall), 0);

      // ori r3 ; addu r3 ; reader of r3 -> youngest (E) wins
      next_cycle(); drv(1, 0, 0, 3, 3, 3, 1, 0, 0, 0);
      next_cycle(); drv(1, 0, 0, 3, 3, 3, 1, 0, 0, 0);
      next_cycle(); drv(1, 3, 0, 0, 3, 11, 1, 0, 0, 0);
      @(negedge clk);
      $display("txn read_r3_youngest");
      chk("youngest_fwd_e", int'(fwd_rs_sel), 1);
      chk("youngest_stall", int'(stall), 0);

      // beq r4,r4 behind a producer with E tnew=1
      next_cycle(); drv(1, 0, 0, 3, 3, 4, 2, 0, 0, 0);
      next_cycle(); drv(1, 4, 4, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      $display("txn beq_r4");
      chk("beq_stall", int'(stall), 1);
      next_cycle();
      @(negedge clk);
      chk("beq_fwd_rs_m", int'(fwd_rs_sel), 2);
      chk("beq_fwd_rt_m", int'(fwd_rt_sel), 2);
      chk("beq_release", int'(stall), 0);

      // $0 destination never forwards nor stalls
      next_cycle(); drv(1, 0, 0, 3, 3, 0, 3, 0, 0, 0);
      next_cycle(); drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      $display("txn read_zero_reg");
      chk("zero_stall", int'(stall), 0);
      chk("zero_fwd_rs", int'(fwd_rs_sel), 0);
      chk("zero_fwd_rt", int'(fwd_rt_sel), 0);

      // div then mflo
      next_cycle(); drv(1, 0, 0, 3, 3, 0, 0, 1, 1, 1);
      @(negedge clk);
      $display("txn div_issue");
      chk("div_accept_stall", int'(stall), 0);
      next_cycle(); drv(1, 0, 0, 3, 3, 2, 1, 0, 0, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("mflo_busy", int'(md_busy), 1);
         chk("mflo_stall", int'(stall), 1);
         next_cycle();
      end
      @(negedge clk);
      $display("txn mflo_released");
      chk("mflo_done_busy", int'(md_busy), 0);
      chk("mflo_done_stall", int'(stall), 0);

      // Randomized traffic with occasional asynchronous resets.
      for (int n = 0; n < 800; n++) begin
         bit mds;
         next_cycle();
         if (!rst_n) rst_n = 1'b1;
         mds = ($urandom_range(15) == 0);
         drv($urandom_range(7) != 0,
             $urandom_range(7), $urandom_range(7),
             $urandom_range(3), $urandom_range(3),
             $urandom_range(7), $urandom_range(3),
             mds, $urandom_range(1) == 1,
             mds || ($urandom_range(5) == 0));
         if ($urandom_range(99) == 0) begin
            #2 rst_n = 1'b0;
            model_reset();
         end
      end
      next_cycle();
      rst_n = 1'b1;
      drv(0, 0, 0, 3, 3, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      cmp_en = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
